// File: rtl/sc_mul_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sc_mul_sched                                                    |
// | Purpose  : Round-robin scheduler sharing one stochastic multiplier.        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sc_mul_sched #(
  parameter int OP_W  = 4,
  parameter int CNT_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2*OP_W-1:0] req_op_a,
  input  logic [2*OP_W-1:0] req_op_b,
  output logic              mul_rst,
  output logic              mul_en,
  output logic [OP_W-1:0]   mul_op_a,
  output logic [OP_W-1:0]   mul_op_b,
  input  logic              mul_done,
  input  logic [CNT_W-1:0]  mul_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [CNT_W-1:0]  rsp_data
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_RUN     = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_last_grant;
  logic             r_id;
  logic [OP_W-1:0]  r_op_a;
  logic [OP_W-1:0]  r_op_b;
  logic [CNT_W-1:0] r_rsp_data;
  logic             w_grant;
  logic [1:0]       w_sel;
  logic             w_accept;

  // Contention goes to whoever was not served last; otherwise the lone requester.
  always_comb begin
    w_grant = 1'b0;
    if (req_valid == 2'b11) begin
      w_grant = ~r_last_grant;
    end else if (req_valid[1]) begin
      w_grant = 1'b1;
    end
  end

  assign w_sel     = {w_grant, ~w_grant};
  assign req_ready = (r_state == S_IDLE && !rst) ? (w_sel & req_valid) : 2'b00;
  assign w_accept  = |(req_valid & req_ready);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = S_CLEAR;
      S_CLEAR:   w_next = S_RUN;
      S_RUN:     if (mul_done) w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_RESP;
      S_RESP:    if (rsp_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_rsp_data   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_last_grant <= w_grant;
        r_id         <= w_grant;
        r_op_a       <= w_grant ? req_op_a[OP_W +: OP_W] : req_op_a[0 +: OP_W];
        r_op_b       <= w_grant ? req_op_b[OP_W +: OP_W] : req_op_b[0 +: OP_W];
      end
      if (r_state == S_CAPTURE) begin
        r_rsp_data <= mul_result;
      end
    end
  end

  // The datapath is held cleared for the whole reset, not just in CLEAR.
  assign mul_rst   = rst | (r_state == S_CLEAR);
  assign mul_en    = (r_state == S_RUN);
  assign mul_op_a  = r_op_a;
  assign mul_op_b  = r_op_b;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_id    = r_id;
  assign rsp_data  = r_rsp_data;

endmodule
`default_nettype wire
